// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared widths, legal-function bound and FSM encoding for the ALU issue sequencer.
package alu_op_sequencer_pkg;
    localparam int ALU_W = 20;
    localparam int ALU_FUNC_W = 4;
    localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_MAX = 4'b0111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_t;

    function automatic logic func_legal(input logic [ALU_FUNC_W-1:0] f);
        return f <= ALU_FUNC_MAX;
    endfunction
endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter: loadable down-counter that stops at zero and flags done while it sits there.
module alu_settle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues requests to the combinational ALU from registered operands,
// waits SETTLE cycles, then returns the captured result over a valid/ready handshake.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH  = ALU_W,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ALU_FUNC_W-1:0] req_func,
    input  logic [WIDTH-1:0]      req_a,
    input  logic [WIDTH-1:0]      req_b,
    input  logic                  req_chain,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [WIDTH-1:0]      alu_in2,
    output logic [ALU_FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]      alu_ans,
    input  logic                  alu_zf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_ans,
    output logic                  rsp_zf,
    output logic                  rsp_err,
    output logic [15:0]           op_count
);
    seq_state_t            state_q;
    logic                  req_ready_q, rsp_valid_q, rsp_zf_q, rsp_err_q, err_pend_q;
    logic [WIDTH-1:0]      alu_in1_q, alu_in2_q, rsp_ans_q, prev_ans_q;
    logic [ALU_FUNC_W-1:0] alu_func_q;
    logic [15:0]           op_count_q;
    logic                  legal, cnt_load, cnt_done;
    logic [3:0]            cnt_val;

    assign legal    = func_legal(req_func);
    assign cnt_load = state_q == IDLE && req_valid;
    // Illegal requests take a single cycle in EXEC so their latency matches a SETTLE=1 op.
    assign cnt_val  = legal ? 4'(SETTLE - 1) : 4'd0;

    alu_settle_counter #(.W(4)) u_settle (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .done_o    (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ans_q   <= '0;
            rsp_zf_q    <= 1'b0;
            err_pend_q  <= 1'b0;
            prev_ans_q  <= '0;
            op_count_q  <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_func_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    state_q     <= EXEC;
                    req_ready_q <= 1'b0;
                    err_pend_q  <= !legal;
                    if (legal) begin
                        alu_func_q <= req_func;
                        alu_in2_q  <= req_b;
                        alu_in1_q  <= req_chain ? prev_ans_q : req_a;
                    end
                end
                EXEC: if (cnt_done) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_pend_q;
                    rsp_ans_q   <= err_pend_q ? '0 : alu_ans;
                    rsp_zf_q    <= !err_pend_q && alu_zf;
                    if (!err_pend_q) begin
                        prev_ans_q <= alu_ans;
                        op_count_q <= op_count_q + 16'd1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ans   = rsp_ans_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;
    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_func  = alu_func_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives a SETTLE=1 and a SETTLE=3 sequencer against ALU stubs and a reference model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], req_valid[2], req_ready[2], req_chain[2], alu_zf[2];
    logic        rsp_valid[2], rsp_ready[2], rsp_zf[2], rsp_err[2];
    logic [3:0]  req_func[2], alu_func[2];
    logic [19:0] req_a[2], req_b[2], alu_in1[2], alu_in2[2], alu_ans[2], rsp_ans[2];
    logic [15:0] op_count[2];

    int n_pass = 0;
    int n_total = 0;

    logic [19:0] m_prev[2], m_in1[2], m_in2[2];
    logic [15:0] m_cnt[2];
    logic [3:0]  m_func[2];

    function automatic logic [19:0] alu_ref(input logic [3:0] f, input logic [19:0] a, b);
        case (f[2:0])
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [43:0] last_q = '0;
        int          age_q = 5;
        logic [19:0] r;
        assign r = alu_ref(alu_func[k], alu_in1[k], alu_in2[k]);
        // The slow stub (k=1) produces garbage until its inputs have been stable for 2+ cycles.
        always @(posedge clk) begin
            if ({alu_func[k], alu_in1[k], alu_in2[k]} != last_q) age_q <= 0;
            else if (age_q < 5) age_q <= age_q + 1;
            last_q <= {alu_func[k], alu_in1[k], alu_in2[k]};
        end
        assign alu_ans[k] = (k == 0 || age_q >= 1) ? r : r ^ 20'h5A5A5;
        assign alu_zf[k]  = alu_ans[k] == 20'd0;

        alu_op_sequencer #(.WIDTH(20), .SETTLE(k == 0 ? 1 : 3)) u_dut (
            .clk      (clk),
            .rst      (rst[k]),
            .req_valid(req_valid[k]),
            .req_ready(req_ready[k]),
            .req_func (req_func[k]),
            .req_a    (req_a[k]),
            .req_b    (req_b[k]),
            .req_chain(req_chain[k]),
            .alu_in1  (alu_in1[k]),
            .alu_in2  (alu_in2[k]),
            .alu_func (alu_func[k]),
            .alu_ans  (alu_ans[k]),
            .alu_zf   (alu_zf[k]),
            .rsp_valid(rsp_valid[k]),
            .rsp_ready(rsp_ready[k]),
            .rsp_ans  (rsp_ans[k]),
            .rsp_zf   (rsp_zf[k]),
            .rsp_err  (rsp_err[k]),
            .op_count (op_count[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset(input int k);
        m_prev[k] = '0;
        m_cnt[k]  = '0;
        m_in1[k]  = '0;
        m_in2[k]  = '0;
        m_func[k] = '0;
    endtask

    task automatic chk_reset_state(input int k);
        chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        chk("rst_rsp_ans", 32'(rsp_ans[k]), 32'd0);
        chk("rst_rsp_zf", 32'(rsp_zf[k]), 32'd0);
        chk("rst_op_count", 32'(op_count[k]), 32'd0);
        chk("rst_alu_in1", 32'(alu_in1[k]), 32'd0);
        chk("rst_alu_in2", 32'(alu_in2[k]), 32'd0);
        chk("rst_alu_func", 32'(alu_func[k]), 32'd0);
    endtask

    // Issue one request from a negedge with the DUT idle, check latency/result, then handshake after hold cycles.
    task automatic op(input int k, input logic [3:0] f, input logic [19:0] a, input logic [19:0] b,
                      input logic ch, input int hold);
        logic        legal;
        logic [19:0] in1, exp_ans;
        int          lat;
        legal   = !f[3];
        in1     = ch ? m_prev[k] : a;
        exp_ans = legal ? alu_ref(f, in1, b) : 20'd0;
        chk("idle_req_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1; req_func[k] = f; req_a[k] = a; req_b[k] = b; req_chain[k] = ch;
        rsp_ready[k] = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b0;
        if (legal) begin
            m_in1[k] = in1; m_in2[k] = b; m_func[k] = f;
        end
        chk("alu_in1", 32'(alu_in1[k]), 32'(m_in1[k]));
        chk("alu_in2", 32'(alu_in2[k]), 32'(m_in2[k]));
        chk("alu_func", 32'(alu_func[k]), 32'(m_func[k]));
        chk("busy_req_ready", 32'(req_ready[k]), 32'd0);
        lat = 0;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), legal ? (k == 0 ? 32'd1 : 32'd3) : 32'd1);
        if (legal) begin
            m_prev[k] = exp_ans;
            m_cnt[k]  = m_cnt[k] + 16'd1;
        end
        chk("rsp_ans", 32'(rsp_ans[k]), 32'(exp_ans));
        chk("rsp_zf", 32'(rsp_zf[k]), 32'(legal && exp_ans == 20'd0));
        chk("rsp_err", 32'(rsp_err[k]), 32'(!legal));
        chk("op_count", 32'(op_count[k]), 32'(m_cnt[k]));
        for (int i = 0; i < hold; i++) begin
            req_valid[k] = 1'b1;
            req_func[k]  = 4'($urandom_range(0, 7));
            req_a[k]     = 20'($urandom);
            req_b[k]     = 20'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            chk("hold_rsp_ans", 32'(rsp_ans[k]), 32'(exp_ans));
            chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
            chk("hold_alu_in1", 32'(alu_in1[k]), 32'(m_in1[k]));
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        chk("post_req_ready", 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_chain[k] = 1'b0; rsp_ready[k] = 1'b0;
            req_func[k] = '0; req_a[k] = '0; req_b[k] = '0;
            model_reset(k);
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk_reset_state(0);
        chk_reset_state(1);

        op(0, 4'd0, 20'd13, 20'd4, 1'b0, 0);
        op(0, 4'b1001, 20'd77, 20'd3, 1'b0, 0);
        op(0, 4'd1, 20'd999, 20'd17, 1'b1, 0);
        op(0, 4'd2, 20'hFFFFF, 20'h0F0F0, 1'b0, 5);
        op(0, 4'd0, 20'hFFFFF, 20'd1, 1'b0, 0);
        for (int i = 0; i < 25; i++)
            op(0, 4'($urandom_range(0, 15)), 20'($urandom), 20'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        op(1, 4'd0, 20'd100, 20'd23, 1'b0, 0);
        op(1, 4'b1111, 20'd5, 20'd5, 1'b0, 1);
        for (int i = 0; i < 25; i++)
            op(1, 4'($urandom_range(0, 15)), 20'($urandom), 20'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        req_valid[1] = 1'b1; req_func[1] = 4'd0; req_a[1] = 20'd40; req_b[1] = 20'd2; req_chain[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst[1] = 1'b1;
        #1;
        model_reset(1);
        chk_reset_state(1);
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
            chk("post_rst_req_ready", 32'(req_ready[1]), 32'd1);
        end
        op(1, 4'd0, 20'd500, 20'd9, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
